packetizer_pe: RTL and testbench

- Transmit-side network interface for one SNN processing element.
- Collects the PE's 8-bit output words (partial sums / potentials) and packs them into 35-bit NoC packets with a destination/source header.
- Emits a completion marker packet that the downstream PE depacketizer recognises as "PE done".
- Sits between the PE output port and the router injection port. It is the mirror of the PE depacketizer.

---
 rtl/packetizer_pe.sv | 175 +++++++++++++++++
 tb/tb_packetizer_pe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/packetizer_pe.sv
// Transmit-side NoC interface for one SNN processing element: packs PE output
// words into 35-bit packets and emits a "PE done" marker packet at end of layer.
module packetizer_pe #(
    parameter int         WIDTH_PACKET  = 35,
    parameter int         WIDTH_PSUM    = 8,
    parameter int         WORDS_PER_PKT = 3,
    parameter logic [2:0] SRC_ADDR      = 3'b011,
    parameter logic [2:0] DEST_ADDR     = 3'b100,
    parameter logic [2:0] DONE_DEST     = 3'b010,
    parameter logic [7:0] DONE_CODE     = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH_PSUM-1:0]   psum_data,
    input  logic                    psum_valid,
    output logic                    psum_ready,
    input  logic                    done_valid,
    output logic                    done_ready,
    output logic [WIDTH_PACKET-1:0] pkt_data,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [15:0]             pkt_count
);

    localparam int BUF_W = 3 * WIDTH_PSUM;

    generate
        if (WORDS_PER_PKT < 1 || WORDS_PER_PKT > 3) begin : g_bad_words_per_pkt
            $error("packetizer_pe: WORDS_PER_PKT must be in 1..3");
        end
    endgenerate

    typedef enum logic [1:0] {
        COLLECT,
        SEND,
        SEND_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BUF_W-1:0]   word_buf;
    logic [BUF_W-1:0]   merged_words;
    logic [1:0]         word_cnt;
    logic [2:0]         cnt_next;
    logic               pending_done;
    logic               word_fire;
    logic               done_fire;
    logic               pkt_fire;
    logic               buf_full;

    function automatic logic [WIDTH_PACKET-1:0] build_pkt(
        input logic [2:0]       dest,
        input logic [4:0]       num_words,
        input logic [BUF_W-1:0] words
    );
        return {dest, SRC_ADDR, num_words, words};
    endfunction

    // Count field of zero is what tells the depacketizer this is a done marker.
    localparam logic [WIDTH_PACKET-1:0] DONE_PKT =
        {DONE_DEST, SRC_ADDR, 5'd0, {(BUF_W - 8){1'b0}}, DONE_CODE};

    assign word_fire = psum_valid && psum_ready;
    assign done_fire = done_valid && done_ready;
    assign pkt_fire  = pkt_valid && pkt_ready;
    assign cnt_next  = {1'b0, word_cnt} + 3'd1;
    assign buf_full  = (cnt_next == 3'(WORDS_PER_PKT));

    always_comb begin
        merged_words = word_buf;
        for (int k = 0; k < 3; k++) begin
            if (word_cnt == 2'(k)) begin
                merged_words[k*WIDTH_PSUM +: WIDTH_PSUM] = psum_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: begin
                if (word_fire) begin
                    if (buf_full) begin
                        next_state = SEND;
                    end
                end else if (done_fire) begin
                    next_state = (word_cnt != 2'd0) ? SEND : SEND_DONE;
                end
            end
            SEND: begin
                if (pkt_fire) begin
                    next_state = pending_done ? SEND_DONE : COLLECT;
                end
            end
            SEND_DONE: begin
                if (pkt_fire) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    // Ready is forced low while reset is held so nothing is accepted mid-reset.
    always_comb begin
        psum_ready = 1'b0;
        done_ready = 1'b0;
        if (state == COLLECT && !rst) begin
            psum_ready = 1'b1;
            done_ready = !psum_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_buf     <= '0;
            word_cnt     <= 2'd0;
            pending_done <= 1'b0;
            pkt_data     <= '0;
            pkt_valid    <= 1'b0;
            pkt_count    <= 16'd0;
        end else begin
            case (state)
                COLLECT: begin
                    if (word_fire) begin
                        if (buf_full) begin
                            pkt_data  <= build_pkt(DEST_ADDR, 5'(WORDS_PER_PKT), merged_words);
                            pkt_valid <= 1'b1;
                            word_buf  <= '0;
                            word_cnt  <= 2'd0;
                        end else begin
                            word_buf <= merged_words;
                            word_cnt <= cnt_next[1:0];
                        end
                    end else if (done_fire) begin
                        if (word_cnt != 2'd0) begin
                            pkt_data     <= build_pkt(DEST_ADDR, {3'b000, word_cnt}, word_buf);
                            pending_done <= 1'b1;
                        end else begin
                            pkt_data <= DONE_PKT;
                        end
                        pkt_valid <= 1'b1;
                        word_buf  <= '0;
                        word_cnt  <= 2'd0;
                    end
                end
                SEND, SEND_DONE: begin
                    if (pkt_fire) begin
                        if (pkt_count != 16'hFFFF) begin
                            pkt_count <= pkt_count + 16'd1;
                        end
                        if (state == SEND && pending_done) begin
                            pkt_data     <= DONE_PKT;
                            pending_done <= 1'b0;
                        end else begin
                            pkt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    pkt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packetizer_pe.sv
// Self-checking bench for packetizer_pe: directed scenarios plus random traffic
// compared against a word-list/packet-queue reference model.
module tb_packetizer_pe;

    localparam int WPP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  psum_data = 8'h00;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic        done_valid = 1'b0;
    logic        done_ready;
    logic [34:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b0;
    logic [15:0] pkt_count;

    int tests = 0;
    int fails = 0;

    logic [7:0]  words_q[$];
    logic [34:0] exp_q[$];
    int          exp_cnt = 0;

    packetizer_pe dut (
        .clk        (clk),
        .rst        (rst),
        .psum_data  (psum_data),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .pkt_data   (pkt_data),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] make_data(input logic [7:0] w[$]);
        logic [34:0] p;
        p = '0;
        p[34:32] = 3'b100;
        p[31:29] = 3'b011;
        p[28:24] = 5'(w.size());
        for (int k = 0; k < w.size(); k++) begin
            p[8*k +: 8] = w[k];
        end
        return p;
    endfunction

    function automatic logic [34:0] make_done();
        logic [34:0] p;
        p = '0;
        p[34:32] = 3'b010;
        p[31:29] = 3'b011;
        p[7:0]   = 8'hFF;
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [34:0] observed,
                               input logic [34:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic applyStimulus(input logic pv, input logic [7:0] pd,
                                 input logic dv, input logic pr);
        logic idle;
        @(negedge clk);
        psum_valid = pv;
        psum_data  = pd;
        done_valid = dv;
        pkt_ready  = pr;
        #1;
        idle = (exp_q.size() == 0);
        checkOutput("psum_ready", {34'd0, psum_ready}, {34'd0, idle});
        checkOutput("done_ready", {34'd0, done_ready}, {34'd0, idle && !pv});
        checkOutput("pkt_valid", {34'd0, pkt_valid}, {34'd0, !idle});
        if (!idle) checkOutput("pkt_data", pkt_data, exp_q[0]);
        checkOutput("pkt_count", {19'd0, pkt_count}, 35'(exp_cnt));
        if (!idle && pr) begin
            void'(exp_q.pop_front());
            if (exp_cnt < 65535) exp_cnt++;
        end else if (idle && pv) begin
            words_q.push_back(pd);
            if (words_q.size() == WPP) begin
                exp_q.push_back(make_data(words_q));
                words_q.delete();
            end
        end else if (idle && dv) begin
            if (words_q.size() > 0) exp_q.push_back(make_data(words_q));
            exp_q.push_back(make_done());
            words_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pkt_valid"}, {34'd0, pkt_valid}, 35'd0);
        checkOutput({tag, "_pkt_data"}, pkt_data, 35'd0);
        checkOutput({tag, "_psum_ready"}, {34'd0, psum_ready}, 35'd0);
        checkOutput({tag, "_done_ready"}, {34'd0, done_ready}, 35'd0);
        checkOutput({tag, "_pkt_count"}, {19'd0, pkt_count}, 35'd0);
    endtask

    task automatic asyncReset(input string tag);
        psum_valid = 1'b0;
        done_valid = 1'b0;
        pkt_ready  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkResetState(tag);
        words_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [34:0] first_pkt;
        first_pkt = {3'b100, 3'b011, 5'd3, 8'h33, 8'h22, 8'h11};

        #3;
        checkResetState("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1, 8'h11, 0, 1);
        applyStimulus(1, 8'h22, 0, 1);
        applyStimulus(1, 8'h33, 0, 1);
        checkOutput("first_pkt_model", exp_q[0], first_pkt);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        applyStimulus(1, 8'h01, 0, 0);
        applyStimulus(1, 8'h02, 0, 0);
        applyStimulus(1, 8'h03, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 8'h04, 0, 0);
        applyStimulus(1, 8'h04, 0, 1);
        applyStimulus(1, 8'h05, 0, 1);
        applyStimulus(1, 8'h06, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        applyStimulus(1, 8'hAA, 0, 1);
        applyStimulus(1, 8'hBB, 0, 1);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        applyStimulus(1, 8'h77, 1, 1);
        applyStimulus(0, 8'h00, 1, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom()),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(1, 8'h5A, 0, 1);
        asyncReset("rst_partial");

        applyStimulus(1, 8'hC1, 0, 0);
        applyStimulus(1, 8'hC2, 0, 0);
        applyStimulus(1, 8'hC3, 0, 0);
        applyStimulus(1, 8'hC4, 0, 0);
        asyncReset("rst_held");

        applyStimulus(1, 8'hD1, 0, 1);
        applyStimulus(1, 8'hD2, 0, 1);
        applyStimulus(1, 8'hD3, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
